// File: rtl/seq_detector_param_moore_pkg.sv
// Shared definitions for the parametrised Moore pattern detector: state encoding,
// pattern-length legality check and the fill-counter width helper.
package seq_detector_param_moore_pkg;

    // State encoding shared by the detector and anything that decodes its state
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;

    typedef enum logic [1:0] {
        StFill  = ST_FILL,
        StArmed = ST_ARMED,
        StMatch = ST_MATCH
    } det_state_e;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 32;

    // True when a pattern length is inside the supported range
    function automatic bit pat_len_legal(input int unsigned len);
        return (len >= PAT_LEN_MIN) && (len <= PAT_LEN_MAX);
    endfunction

    // Bits needed for a fill counter that must reach the value len itself
    function automatic int unsigned fill_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter for seq_detector_param_moore.
// Only exists in builds with SEQDET_MATCH_COUNT_EN defined, so counter-less builds
// carry no trace of it.
`ifdef SEQDET_MATCH_COUNT_EN
module seq_det_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_count_nxt;

    // Next count: step on inc, stick at all-ones instead of wrapping
    always_comb begin
        w_count_nxt = r_count;
        if (inc && !(&r_count)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Count and saturation flag update together so sat always matches count
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_sat   <= &w_count_nxt;
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule
`endif

// File: rtl/seq_detector_param_moore.sv
// Parametrised Moore serial pattern detector with runtime-loadable pattern and overlap
// mode, valid-qualified input and an optional saturating match counter.
// Build option: SEQDET_MATCH_COUNT_EN enables match_count/count_sat; otherwise both are 0.
module seq_detector_param_moore
    import seq_detector_param_moore_pkg::*;
#(
    parameter int unsigned        PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
    parameter int unsigned        CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int unsigned        FILL_W = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    if (!pat_len_legal(PAT_LEN)) begin : g_bad_pat_len
        $error("seq_detector_param_moore: PAT_LEN must be within 2..32");
    end

    logic [PAT_LEN-1:0] r_pat;
    logic               r_overlap;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    det_state_e         r_state;
    logic               r_det;

    logic [PAT_LEN-1:0] w_hist_shift;
    logic [FILL_W-1:0]  w_fill_inc;
    logic               w_hit;

    // History/fill as they would be after accepting the current bit, and whether that
    // completes the pattern; fill counts only bits gathered since the last clear
    always_comb begin
        w_hist_shift = {r_hist[PAT_LEN-2:0], sequence_in};
        w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
        w_hit        = (w_fill_inc == FILL_FULL) && (w_hist_shift == r_pat);
    end

    // Detector FSM; cfg_load outranks an accepted bit, and MATCH never outlives one cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pat     <= DEFAULT_PAT;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= StFill;
            r_det     <= 1'b0;
        end else if (cfg_load) begin
            r_pat     <= cfg_pattern;
            r_overlap <= cfg_overlap;
            r_fill    <= '0;
            r_state   <= StFill;
            r_det     <= 1'b0;
        end else if (in_valid) begin
            r_hist <= w_hist_shift;
            if (w_hit) begin
                r_state <= StMatch;
                r_det   <= 1'b1;
                // Non-overlap mode must see a whole fresh pattern before the next hit
                r_fill  <= r_overlap ? FILL_FULL : '0;
            end else begin
                r_fill  <= w_fill_inc;
                r_state <= (w_fill_inc == FILL_FULL) ? StArmed : StFill;
                r_det   <= 1'b0;
            end
        end else begin
            r_det <= 1'b0;
            if (r_state == StMatch) begin
                r_state <= r_overlap ? StArmed : StFill;
            end
        end
    end

    assign detector_out = r_det;

`ifdef SEQDET_MATCH_COUNT_EN
    logic w_count_inc;

    // One increment per entry into MATCH; reset is applied inside the counter
    always_comb begin
        w_count_inc = in_valid && !cfg_load && w_hit;
    end

    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clock (clock),
        .reset (reset),
        .inc   (w_count_inc),
        .count (match_count),
        .sat   (count_sat)
    );
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param_moore.sv
// Self-checking bench for seq_detector_param_moore: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
// Counter expectations follow SEQDET_MATCH_COUNT_EN as defined for the build.
module tb_seq_detector_param_moore;

    localparam int unsigned PAT_LEN = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [PAT_LEN-1:0] DEF_PAT = 4'b1011;

    logic               clock;
    logic               reset;
    logic               sequence_in;
    logic               in_valid;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    seq_detector_param_moore #(
        .PAT_LEN     (PAT_LEN),
        .DEFAULT_PAT (DEF_PAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_overlap  (cfg_overlap),
        .detector_out (detector_out),
        .match_count  (match_count),
        .count_sat    (count_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: bits gathered since the last clear, newest at the back
    bit          m_hist[$];
    int unsigned m_pat   = DEF_PAT;
    bit          m_ovl   = 1'b1;
    int unsigned m_count = 0;
    bit          m_det   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int unsigned hist_value();
        int unsigned v = 0;
        foreach (m_hist[i]) v = (v << 1) | int'(m_hist[i]);
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare all outputs
    task automatic step(input bit rst_n, input bit vld, input bit ld,
                        input logic [PAT_LEN-1:0] pat, input bit ovl, input bit din);
        int unsigned exp_cnt;
        bit          exp_sat;
        reset       = rst_n;
        in_valid    = vld;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        sequence_in = din;
        @(posedge clock);
        #1;
        m_det = 1'b0;
        if (!rst_n) begin
            m_hist.delete();
            m_pat   = DEF_PAT;
            m_ovl   = 1'b1;
            m_count = 0;
        end else if (ld) begin
            m_pat = pat;
            m_ovl = ovl;
            m_hist.delete();
        end else if (vld) begin
            m_hist.push_back(din);
            if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
            if (m_hist.size() == PAT_LEN && hist_value() == m_pat) begin
                m_det = 1'b1;
                if (m_count < CNT_MAX) m_count++;
                if (!m_ovl) m_hist.delete();
            end
        end
`ifdef SEQDET_MATCH_COUNT_EN
        exp_cnt = m_count;
        exp_sat = (m_count == CNT_MAX);
`else
        exp_cnt = 0;
        exp_sat = 1'b0;
`endif
        check_val("detector_out", 32'(detector_out), 32'(m_det));
        check_val("match_count", 32'(match_count), exp_cnt);
        check_val("count_sat", 32'(count_sat), 32'(exp_sat));
    endtask

    task automatic bit_in(input bit din);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, din);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PAT_LEN-1:0] pat, input bit ovl);
        step(1'b1, 1'b0, 1'b1, pat, ovl, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [31:0] seen;
    logic [6:0]  stream;

    initial begin
        reset       = 1'b0;
        sequence_in = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_overlap = 1'b0;
        do_reset();
        do_reset();

        // Default pattern 1011 with overlap: pulses after bits 4 and 7
        stream = 7'b1011011;
        seen = '0;
        for (int i = 0; i < 7; i++) begin
            bit_in(stream[6-i]);
            seen[i] = detector_out;
        end
        check_val("t1_pulses", seen, 32'b1001000);
`ifdef SEQDET_MATCH_COUNT_EN
        check_val("t1_count", 32'(match_count), 32'd2);
`endif

        // Same stream without overlap: only the first match
        load(4'b1011, 1'b0);
        seen = '0;
        for (int i = 0; i < 7; i++) begin
            bit_in(stream[6-i]);
            seen[i] = detector_out;
        end
        check_val("t2_pulses", seen, 32'b0001000);

        // Valid gap in the middle of a pattern
        load(4'b1011, 1'b1);
        seen = '0;
        bit_in(1'b1); seen[0] = detector_out;
        bit_in(1'b0); seen[1] = detector_out;
        for (int i = 2; i < 5; i++) begin
            idle();
            seen[i] = detector_out;
        end
        bit_in(1'b1); seen[5] = detector_out;
        bit_in(1'b1); seen[6] = detector_out;
        check_val("t3_pulses", seen, 32'b1000000);

        // Reset mid-pattern discards history; a fresh full pattern still matches
        seen = '0;
        bit_in(1'b1); seen[0] = detector_out;
        bit_in(1'b0); seen[1] = detector_out;
        bit_in(1'b1); seen[2] = detector_out;
        do_reset();   seen[3] = detector_out;
        bit_in(1'b1); seen[4] = detector_out;
        bit_in(1'b0); seen[5] = detector_out;
        bit_in(1'b1); seen[6] = detector_out;
        bit_in(1'b1); seen[7] = detector_out;
        check_val("t4_pulses", seen, 32'b10000000);

        // All-ones pattern: consecutive pulses with overlap, isolated without
        load(4'b1111, 1'b1);
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            seen[i] = detector_out;
        end
        check_val("t5_overlap", seen, 32'b111000);
        load(4'b1111, 1'b0);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            bit_in(1'b1);
            seen[i] = detector_out;
        end
        check_val("t5_no_overlap", seen, 32'b10001000);

        // Drive the counter into saturation and beyond
        load(4'b1111, 1'b1);
        for (int i = 0; i < 24; i++) bit_in(1'b1);
`ifdef SEQDET_MATCH_COUNT_EN
        check_val("t6_count_sat_val", 32'(match_count), CNT_MAX);
        check_val("t6_sat_flag", 32'(count_sat), 32'd1);
`else
        check_val("t6_count_off", 32'(match_count), 32'd0);
        check_val("t6_sat_off", 32'(count_sat), 32'd0);
`endif
        check_val("t6_det_still", 32'(detector_out), 32'd1);

        // Random traffic with occasional reconfiguration and reset
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                load(PAT_LEN'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else if (r < 80) begin
                bit_in(1'($urandom_range(0, 1)));
            end else begin
                idle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
